serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 26 ++
 rtl/serial_subtractor_full_sub.sv | 19 +
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t      : FSM encoding (IDLE=0, SHIFT=1, DONE=2)
//   width_legal  : legal WIDTH range check used at elaboration
//   cnt_width    : bit-counter width, $clog2(WIDTH) with a minimum of 1
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor: d = a - b - bin, purely combinational.
// Ports:
//   a, b  : operand bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor_nodelay (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, LSB first,
// one bit per clock through a single full-subtractor cell.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand handshake (ready only in IDLE)
//   A, B, Bin           : minuend, subtrahend, borrow in
//   out_valid, out_ready: result handshake (valid only in DONE)
//   D, Bout, V          : difference, unsigned borrow out, signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  generate
    if (!width_legal(WIDTH)) begin : g_width_check
      $error("serial_subtractor: WIDTH must be in 2..32");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor_nodelay u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    bout_d   = bout_q;
    v_d      = v_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d   = A;
          b_sh_d   = B;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = {fs_d, res_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // borrow_q here is the borrow into the MSB; overflow is when it
          // differs from the borrow out of the MSB.
          dout_d  = {fs_d, res_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          v_d     = borrow_q ^ fs_bout;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= '0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign D         = dout_q;
  assign Bout      = bout_q;
  assign V         = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .V         (V)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {D, Bout, V} in issue order.
  logic [WIDTH+1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result transfers at the next rising edge when valid and ready
  // are both high, so check it on the falling edge before that.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {26'd0, D, Bout, V}, 32'hFFFF_FFFF);
      end else begin
        chk("result_DBV", {26'd0, D, Bout, V}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Issue one operation with out_ready=1; checks latency and return to IDLE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic [WIDTH-1:0] ed,
                        input logic eb, input logic ev);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    exp_q.push_back({ed, eb, ev});
    @(posedge clk); #1;  // E0
    in_valid = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;  // later operand changes must not matter
    wait_out_valid(lat);
    chk("latency", lat, WIDTH);
    @(posedge clk); #1;
    chk("in_ready_after_result", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int lat;
    logic [WIDTH+1:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Bin = 1'b0;
    #3;
    chk("reset_state", {24'd0, in_ready, out_valid, D, Bout, V}, {24'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed {D, Bout, V}.
    run_op(4'd7,    4'd3, 1'b0, 4'd4,    1'b0, 1'b0);
    run_op(4'd3,    4'd5, 1'b0, 4'b1110, 1'b1, 1'b0);
    run_op(4'b1000, 4'd1, 1'b0, 4'b0111, 1'b0, 1'b1);
    run_op(4'd0,    4'd0, 1'b1, 4'b1111, 1'b1, 1'b0);
    run_op(4'd5,    4'd5, 1'b0, 4'd0,    1'b0, 1'b0);
    run_op(4'd7,    4'd15,1'b0, 4'd8,    1'b1, 1'b1);  // 7-(-1)=8 overflows
    run_op(4'd15,   4'd14,1'b1, 4'd0,    1'b0, 1'b0);

    // Backpressure: hold the result while new operands are offered.
    out_ready = 1'b0;
    A = 4'd6; B = 4'd1; Bin = 1'b0; in_valid = 1'b1;
    exp_q.push_back({4'd5, 1'b0, 1'b0});
    @(posedge clk); #1;
    A = 4'd2; B = 4'd3; Bin = 1'b0;  // stays offered through SHIFT and DONE
    exp_q.push_back({4'b1111, 1'b1, 1'b0});
    wait_out_valid(lat);
    chk("bp_latency", lat, WIDTH);
    held = {D, Bout, V};
    chk("bp_first_value", {26'd0, held}, {26'd0, 4'd5, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {24'd0, in_ready, out_valid, D, Bout, V}, {24'd0, 1'b0, 1'b1, held});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_back_to_idle", {30'd0, in_ready, out_valid}, 32'd2);
    @(posedge clk); #1;
    chk("bp_accept_held_valid", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_out_valid(lat);
    chk("bp_second_latency", lat, WIDTH);
    @(posedge clk); #1;

    // Reset during SHIFT discards the operation.
    A = 4'd7; B = 4'd1; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {24'd0, in_ready, out_valid, D, Bout, V}, {24'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(4'd9, 4'd2, 1'b0, 4'd7, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
